// File: rtl/execute_stage_pkg.sv
// Shared encodings, FSM state type and the execute->memory payload for execute_stage.
package execute_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [2:0] LONG_MUL    = 3'd0;
  localparam logic [2:0] LONG_MULH   = 3'd1;
  localparam logic [2:0] LONG_MULHSU = 3'd2;
  localparam logic [2:0] LONG_MULHU  = 3'd3;
  localparam logic [2:0] LONG_DIV    = 3'd4;
  localparam logic [2:0] LONG_DIVU   = 3'd5;
  localparam logic [2:0] LONG_REM    = 3'd6;
  localparam logic [2:0] LONG_REMU   = 3'd7;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t BUSY = 2'd1;
  localparam state_t DONE = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [3:0]      op_type;
    logic            is_memory_instruction;
    logic            reg_wb_en;
    logic            is_long;
    logic [4:0]      rd_label;
    logic [1:0]      wb_sel;
  } ex_mem_t;

  // Operand A is treated as signed for these ops.
  function automatic logic long_a_signed(input logic [2:0] op);
    return (op == LONG_MUL) || (op == LONG_MULH) || (op == LONG_MULHSU) ||
           (op == LONG_DIV) || (op == LONG_REM);
  endfunction

  function automatic logic long_b_signed(input logic [2:0] op);
    return (op == LONG_MUL) || (op == LONG_MULH) || (op == LONG_DIV) || (op == LONG_REM);
  endfunction

endpackage

// File: rtl/execute_stage_long_op_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide on magnitudes.
// FAST_MUL_EN: multiplies use a combinational multiplier and skip the BUSY phase.
module execute_stage_long_op_unit
  import execute_stage_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic            ack_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_c,
  output logic            done_c
);

  localparam int unsigned CNT_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;

  logic                a_sgn, b_sgn;
  logic [XLEN-1:0]     abs_a, abs_b;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next, div_next, prod_fix;
  logic [XLEN:0]       div_trial;
  logic [XLEN-1:0]     div_diff;
  logic                div_ge;
`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0]   a_ext, b_ext, fast_prod;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
    end
  end

  // Next state plus operand latch and one iteration step per BUSY cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    op_d    = op_q;
    neg_d   = neg_q;

    a_sgn = long_a_signed(op_i) & a_i[XLEN-1];
    b_sgn = long_b_signed(op_i) & b_i[XLEN-1];
    abs_a = a_sgn ? -a_i : a_i;
    abs_b = b_sgn ? -b_i : b_i;

    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};

    div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = div_trial >= {1'b0, opb_q};
    div_diff  = div_trial[XLEN-1:0] - opb_q;
    div_next  = {(div_ge ? div_diff : div_trial[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};

`ifdef FAST_MUL_EN
    a_ext     = {{XLEN{a_sgn}}, a_i};
    b_ext     = {{XLEN{b_sgn}}, b_i};
    fast_prod = a_ext * b_ext;
`endif

    case (state_q)
      IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          opb_d   = abs_b;
          acc_d   = {{XLEN{1'b0}}, abs_a};
          cnt_d   = '0;
          state_d = BUSY;
          if (!op_i[2])     neg_d = a_sgn ^ b_sgn;
          else if (op_i[1]) neg_d = a_sgn;
          else              neg_d = (a_sgn ^ b_sgn) & (|b_i);
`ifdef FAST_MUL_EN
          if (!op_i[2]) begin
            acc_d   = fast_prod;
            neg_d   = 1'b0;
            state_d = DONE;
          end
`endif
        end
      end
      BUSY: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LONG_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Sign fix and word select from the finished accumulator.
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    case (op_q)
      LONG_MUL:                          result_c = prod_fix[XLEN-1:0];
      LONG_MULH, LONG_MULHSU, LONG_MULHU: result_c = prod_fix[2*XLEN-1:XLEN];
      LONG_DIV, LONG_DIVU:               result_c = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      default:                           result_c = neg_q ? -acc_q[2*XLEN-1:XLEN]
                                                          : acc_q[2*XLEN-1:XLEN];
    endcase
    done_c = (state_q == DONE);
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU, iterative RV32M unit and the execute->memory register.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        busywait_i,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] pc_i,
  input  logic        alu_src_imm_i,
  input  logic [3:0]  alu_op_i,
  input  logic        is_long_i,
  input  logic [2:0]  long_op_i,
  input  logic [3:0]  op_type_i,
  input  logic        is_memory_instruction_i,
  input  logic        reg_wb_en_i,
  input  logic [4:0]  rd_label_i,
  input  logic [1:0]  wb_sel_i,
  output logic        stall_o,
  output logic [31:0] alu_out_o,
  output logic [31:0] rs2_data_o,
  output logic [31:0] imm_o,
  output logic [31:0] pc_o,
  output logic [3:0]  op_type_o,
  output logic        is_memory_instruction_o,
  output logic        reg_wb_en_o,
  output logic        is_long_o,
  output logic [4:0]  rd_label_o,
  output logic [1:0]  wb_sel_o
);

  ex_mem_t         ex_q, ex_d;
  logic [XLEN-1:0] opb, alu_res, long_result;
  logic [4:0]      shamt;
  logic            long_done;

  execute_stage_long_op_unit #(
    .LONG_CYCLES (LONG_CYCLES)
  ) u_long_op_unit (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (valid_i & is_long_i & ~flush_i),
    .flush_i  (flush_i),
    .ack_i    (~busywait_i),
    .op_i     (long_op_i),
    .a_i      (rs1_data_i),
    .b_i      (rs2_data_i),
    .result_c (long_result),
    .done_c   (long_done)
  );

  // Single-cycle ALU.
  always_comb begin
    opb   = alu_src_imm_i ? imm_i : rs2_data_i;
    shamt = opb[4:0];
    case (alu_op_i)
      ALU_ADD:  alu_res = rs1_data_i + opb;
      ALU_SUB:  alu_res = rs1_data_i - opb;
      ALU_SLL:  alu_res = rs1_data_i << shamt;
      ALU_SLT:  alu_res = XLEN'($signed(rs1_data_i) < $signed(opb));
      ALU_SLTU: alu_res = XLEN'(rs1_data_i < opb);
      ALU_XOR:  alu_res = rs1_data_i ^ opb;
      ALU_SRL:  alu_res = rs1_data_i >> shamt;
      ALU_SRA:  alu_res = $signed(rs1_data_i) >>> shamt;
      ALU_OR:   alu_res = rs1_data_i | opb;
      ALU_AND:  alu_res = rs1_data_i & opb;
      default:  alu_res = '0;
    endcase
  end

  assign stall_o = busywait_i | (valid_i & is_long_i & ~long_done);

  // Output register next value: hold on busywait, bubble unless a result is ready.
  always_comb begin
    ex_d = ex_q;
    if (!busywait_i) begin
      ex_d = '0;
      if (valid_i && !flush_i && (!is_long_i || long_done)) begin
        ex_d.alu_out               = is_long_i ? long_result : alu_res;
        ex_d.rs2_data              = rs2_data_i;
        ex_d.imm                   = imm_i;
        ex_d.pc                    = pc_i;
        ex_d.op_type               = op_type_i;
        ex_d.is_memory_instruction = is_memory_instruction_i;
        ex_d.reg_wb_en             = reg_wb_en_i;
        ex_d.is_long               = is_long_i;
        ex_d.rd_label              = rd_label_i;
        ex_d.wb_sel                = wb_sel_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ex_q <= '0;
    else         ex_q <= ex_d;
  end

  assign alu_out_o               = ex_q.alu_out;
  assign rs2_data_o              = ex_q.rs2_data;
  assign imm_o                   = ex_q.imm;
  assign pc_o                    = ex_q.pc;
  assign op_type_o               = ex_q.op_type;
  assign is_memory_instruction_o = ex_q.is_memory_instruction;
  assign reg_wb_en_o             = ex_q.reg_wb_en;
  assign is_long_o               = ex_q.is_long;
  assign rd_label_o              = ex_q.rd_label;
  assign wb_sel_o                = ex_q.wb_sel;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage (serial or FAST_MUL_EN build).
module tb_execute_stage;

`ifdef FAST_MUL_EN
  localparam int MUL_STALL = 1;
`else
  localparam int MUL_STALL = 33;
`endif
  localparam int DIV_STALL = 33;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busywait, flush, valid;
  logic [31:0] rs1, rs2, imm, pc;
  logic        alu_src_imm;
  logic [3:0]  alu_op;
  logic        is_long;
  logic [2:0]  long_op;
  logic [3:0]  op_type;
  logic        is_mem, reg_wb_en;
  logic [4:0]  rd_label;
  logic [1:0]  wb_sel;

  logic        stall_o;
  logic [31:0] alu_out_o, rs2_data_o, imm_o, pc_o;
  logic [3:0]  op_type_o;
  logic        is_mem_o, reg_wb_en_o, is_long_o;
  logic [4:0]  rd_label_o;
  logic [1:0]  wb_sel_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk_i                   (clk),
    .rst_ni                  (rst_n),
    .busywait_i              (busywait),
    .flush_i                 (flush),
    .valid_i                 (valid),
    .rs1_data_i              (rs1),
    .rs2_data_i              (rs2),
    .imm_i                   (imm),
    .pc_i                    (pc),
    .alu_src_imm_i           (alu_src_imm),
    .alu_op_i                (alu_op),
    .is_long_i               (is_long),
    .long_op_i               (long_op),
    .op_type_i               (op_type),
    .is_memory_instruction_i (is_mem),
    .reg_wb_en_i             (reg_wb_en),
    .rd_label_i              (rd_label),
    .wb_sel_i                (wb_sel),
    .stall_o                 (stall_o),
    .alu_out_o               (alu_out_o),
    .rs2_data_o              (rs2_data_o),
    .imm_o                   (imm_o),
    .pc_o                    (pc_o),
    .op_type_o               (op_type_o),
    .is_memory_instruction_o (is_mem_o),
    .reg_wb_en_o             (reg_wb_en_o),
    .is_long_o               (is_long_o),
    .rd_label_o              (rd_label_o),
    .wb_sel_o                (wb_sel_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    busywait = 0; flush = 0; valid = 0; rs1 = 0; rs2 = 0; imm = 0; pc = 0;
    alu_src_imm = 0; alu_op = 0; is_long = 0; long_op = 0; op_type = 0;
    is_mem = 0; reg_wb_en = 0; rd_label = 0; wb_sel = 0;
  endtask

  task automatic alu_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic use_imm, input logic [31:0] exp);
    valid = 1; is_long = 0; alu_op = op; rs1 = a; alu_src_imm = use_imm;
    imm = use_imm ? b : 32'h0BAD_F00D;
    rs2 = use_imm ? 32'h1357_9BDF : b;
    reg_wb_en = 1; rd_label = 5'd3; wb_sel = 2'd2; op_type = 4'h5; is_mem = 1; pc = 32'h0000_1000;
    #1 check({tag, "_stall"}, 32'(stall_o), 32'd0);
    step;
    check(tag, alu_out_o, exp);
    check({tag, "_wb"}, 32'(reg_wb_en_o), 32'd1);
    valid = 0;
  endtask

  // Issue a long op, count stalled cycles, then check the loaded result.
  task automatic long_vec(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
    int n;
    valid = 1; is_long = 1; long_op = op; rs1 = a; rs2 = b; alu_op = 4'd0; alu_src_imm = 0;
    reg_wb_en = 1; rd_label = 5'd9; wb_sel = 2'd1; is_mem = 0; op_type = 4'd0; pc = 32'h0000_2000;
    n = 0;
    #1;
    while (stall_o && n < 200) begin
      n++;
      step;
    end
    step;
    check({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    check(tag, alu_out_o, exp);
    check({tag, "_is_long"}, 32'(is_long_o), 32'd1);
    check({tag, "_rd"}, 32'(rd_label_o), 32'd9);
    valid = 0; is_long = 0;
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    step; step;
    check("rst_alu_out", alu_out_o, 32'd0);
    check("rst_wb_en", 32'(reg_wb_en_o), 32'd0);
    check("rst_is_long", 32'(is_long_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    rst_n = 1;
    step;

    // ALU vectors
    alu_vec("add_imm", 4'd0, 32'd5, 32'hFFFF_FFFD, 1'b1, 32'd2);
    check("add_rs2_fwd", rs2_data_o, 32'h1357_9BDF);
    check("add_imm_fwd", imm_o, 32'hFFFF_FFFD);
    check("add_pc_fwd", pc_o, 32'h0000_1000);
    check("add_rd_fwd", 32'(rd_label_o), 32'd3);
    check("add_optype_fwd", 32'(op_type_o), 32'h5);
    check("add_wbsel_fwd", 32'(wb_sel_o), 32'd2);
    check("add_mem_fwd", 32'(is_mem_o), 32'd1);
    check("add_is_long", 32'(is_long_o), 32'd0);
    alu_vec("sub", 4'd1, 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE);
    alu_vec("sll", 4'd2, 32'd1, 32'h0000_0021, 1'b0, 32'd2);
    alu_vec("slt", 4'd3, 32'hFFFF_FFFF, 32'd5, 1'b0, 32'd1);
    alu_vec("sltu", 4'd4, 32'hFFFF_FFFF, 32'd5, 1'b0, 32'd0);
    alu_vec("xor", 4'd5, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 32'hFF00_EDCB);
    alu_vec("srl", 4'd6, 32'h8000_0000, 32'd4, 1'b0, 32'h0800_0000);
    alu_vec("sra", 4'd7, 32'h8000_0000, 32'd4, 1'b1, 32'hF800_0000);
    alu_vec("or", 4'd8, 32'h0000_00F0, 32'h0000_0F0F, 1'b0, 32'h0000_0FFF);
    alu_vec("and", 4'd9, 32'h0000_00F0, 32'h0000_0F3F, 1'b0, 32'h0000_0030);
    alu_vec("op12", 4'd12, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'd0);
    step;
    check("bubble_wb", 32'(reg_wb_en_o), 32'd0);

    // Long ops and RISC-V corner cases
    long_vec("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_STALL);
    long_vec("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, DIV_STALL);
    long_vec("divu_0", 3'd5, 32'd7, 32'd0, 32'hFFFF_FFFF, DIV_STALL);
    long_vec("rem_0", 3'd6, 32'd7, 32'd0, 32'd7, DIV_STALL);
    long_vec("div_neg0", 3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, DIV_STALL);
    long_vec("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_STALL);
    long_vec("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_STALL);
    long_vec("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_STALL);
    long_vec("mulh", 3'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, MUL_STALL);
    long_vec("mul", 3'd0, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, MUL_STALL);
    long_vec("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_STALL);

    // Result completes while the memory stage stalls
    valid = 1; is_long = 1; long_op = 3'd4; rs1 = 32'd100; rs2 = 32'd7; reg_wb_en = 1;
    #1;
    repeat (33) step;
    busywait = 1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bw_stall", 32'(stall_o), 32'd1);
      step;
    end
    check("bw_hold_out", alu_out_o, 32'd0);
    check("bw_hold_long", 32'(is_long_o), 32'd0);
    busywait = 0;
    #1 check("bw_stall_drop", 32'(stall_o), 32'd0);
    step;
    check("bw_result", alu_out_o, 32'd14);
    check("bw_is_long", 32'(is_long_o), 32'd1);
    valid = 0; is_long = 0;
    step;

    // Flush mid-BUSY kills the op; next instructions see a clean FSM
    valid = 1; is_long = 1; long_op = 3'd4; rs1 = 32'h8000_0000; rs2 = 32'hFFFF_FFFF; reg_wb_en = 1;
    #1;
    repeat (11) step;
    flush = 1;
    step;
    flush = 0; is_long = 0;
    check("flush_bubble_wb", 32'(reg_wb_en_o), 32'd0);
    check("flush_bubble_long", 32'(is_long_o), 32'd0);
    alu_vec("flush_add", 4'd0, 32'd40, 32'd2, 1'b0, 32'd42);
    long_vec("flush_div", 3'd4, 32'd100, 32'd7, 32'd14, DIV_STALL);
    // Flush on a plain ALU op also yields a bubble
    valid = 1; alu_op = 4'd0; rs1 = 32'd1; rs2 = 32'd1; reg_wb_en = 1; flush = 1;
    step;
    flush = 0; valid = 0;
    check("flush_alu_wb", 32'(reg_wb_en_o), 32'd0);
    check("flush_alu_out", alu_out_o, 32'd0);

    // Asynchronous reset in the middle of a DIV
    alu_vec("add_pre", 4'd0, 32'd5, 32'd3, 1'b0, 32'd8);
    busywait = 1;
    valid = 1; is_long = 1; long_op = 3'd4; rs1 = 32'd100; rs2 = 32'd3; reg_wb_en = 1; pc = 32'h44;
    #1;
    repeat (10) step;
    check("bw_hold_pre", alu_out_o, 32'd8);
    #3 rst_n = 0;
    #1;
    check("arst_alu_out", alu_out_o, 32'd0);
    check("arst_wb_en", 32'(reg_wb_en_o), 32'd0);
    check("arst_pc", pc_o, 32'd0);
    check("arst_rd", 32'(rd_label_o), 32'd0);
    clear_inputs();
    step; step;
    rst_n = 1;
    step;
    long_vec("div_after_rst", 3'd4, 32'd100, 32'd7, 32'd14, DIV_STALL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
